// File: rtl/axi_lite_reg_writer_if.sv
// AXI4-Lite write-side bundle (AW, W, B channels) between a bus master and the register writer.
interface axi_lite_reg_writer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_reg_writer.sv
// AXI4-Lite write terminator holding eight slave registers r0..r7; AW and W may arrive in any
// order, each write commits with byte strobes and returns one OKAY response.
module axi_lite_reg_writer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int OPT_MEM_ADDR_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  axi_lite_reg_writer_if.slave          s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r3,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r4,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r5,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r6,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r7,
  output logic [7:0]                    reg_wr
);
  // state     | meaning
  // IDLE      | no half of a write held
  // ADDR_ONLY | address accepted, waiting for data
  // DATA_ONLY | data accepted, waiting for address
  // RESP      | write committed, bvalid high until bready
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = DW / 32 + 1;
  localparam int IW       = OPT_MEM_ADDR_BITS + 1;
  localparam int NREG     = 8;

  typedef enum logic [1:0] {IDLE, ADDR_ONLY, DATA_ONLY, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [7:0]      reg_wr_q, reg_wr_d;

  logic aw_held, w_held, bvalid;
  logic aw_hs, w_hs, commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_live;
  logic unused_addr_bits;

  assign awaddr_live      = s_axi.awaddr;
  assign unused_addr_bits = ^awaddr_live[ADDR_LSB-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    aw_hs   = s_axi.awvalid & s_axi.awready;
    w_hs    = s_axi.wvalid & s_axi.wready;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = RESP;
        else if (aw_hs)    state_d = ADDR_ONLY;
        else if (w_hs)     state_d = DATA_ONLY;
      end
      ADDR_ONLY: if (w_hs)         state_d = RESP;
      DATA_ONLY: if (aw_hs)        state_d = RESP;
      RESP:      if (s_axi.bready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    commit = (state_d == RESP) && (state_q != RESP);
  end

  // Outputs; readies drop during reset so nothing is accepted while it is asserted
  always_comb begin
    aw_held       = (state_q == ADDR_ONLY);
    w_held        = (state_q == DATA_ONLY);
    bvalid        = (state_q == RESP);
    s_axi.bvalid  = bvalid;
    s_axi.bresp   = 2'b00;
    s_axi.awready = ~reset & ~aw_held & ~bvalid;
    s_axi.wready  = ~reset & ~w_held & ~bvalid;
  end

  // The half completing this cycle comes from the live channel, the other from its holding reg
  always_comb begin
    idx_d    = aw_hs ? awaddr_live[ADDR_LSB +: IW] : idx_q;
    data_d   = w_hs ? s_axi.wdata : data_q;
    strb_d   = w_hs ? s_axi.wstrb : strb_q;
    regs_d   = regs_q;
    reg_wr_d = '0;
    if (commit) begin
      reg_wr_d[idx_d] = 1'b1;
      for (int i = 0; i < SW; i++) begin
        if (strb_d[i]) regs_d[idx_d][8*i +: 8] = data_d[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      reg_wr_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      idx_q    <= idx_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      reg_wr_q <= reg_wr_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign reg_wr = reg_wr_q;
  assign r0     = regs_q[0];
  assign r1     = regs_q[1];
  assign r2     = regs_q[2];
  assign r3     = regs_q[3];
  assign r4     = regs_q[4];
  assign r5     = regs_q[5];
  assign r6     = regs_q[6];
  assign r7     = regs_q[7];
endmodule

// File: tb/tb_axi_lite_reg_writer.sv
// Directed bench for axi_lite_reg_writer: transaction-queue model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_axi_lite_reg_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  reg_wr;
  logic [31:0] dut_r [8];

  int n_checks = 0;
  int n_pass   = 0;

  axi_lite_reg_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  axi_lite_reg_writer #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .OPT_MEM_ADDR_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(bus),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .reg_wr(reg_wr)
  );

  assign dut_r[0] = r0;
  assign dut_r[1] = r1;
  assign dut_r[2] = r2;
  assign dut_r[3] = r3;
  assign dut_r[4] = r4;
  assign dut_r[5] = r5;
  assign dut_r[6] = r6;
  assign dut_r[7] = r7;

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Model: accepted address and data halves are queued; a pair is consumed as one write
  logic [4:0]  m_aw_q [$];
  logic [31:0] m_wd_q [$];
  logic [3:0]  m_ws_q [$];
  logic [31:0] m_regs [8] = '{default: 32'h0};
  logic [7:0]  m_regwr = 8'h0;
  logic        m_bv = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_aw_q.delete();
      m_wd_q.delete();
      m_ws_q.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_regwr = 8'h0;
      m_bv    = 1'b0;
    end else begin
      logic aw_ok, w_ok, b_done;
      aw_ok  = bus.awvalid && (m_aw_q.size() == 0) && !m_bv;
      w_ok   = bus.wvalid && (m_wd_q.size() == 0) && !m_bv;
      b_done = m_bv && bus.bready;
      if (aw_ok) m_aw_q.push_back(bus.awaddr);
      if (w_ok) begin
        m_wd_q.push_back(bus.wdata);
        m_ws_q.push_back(bus.wstrb);
      end
      m_regwr = 8'h0;
      if (b_done) m_bv = 1'b0;
      if (m_aw_q.size() > 0 && m_wd_q.size() > 0) begin
        int idx;
        logic [31:0] d;
        logic [3:0]  s;
        idx = int'(m_aw_q.pop_front()) / 4;
        d   = m_wd_q.pop_front();
        s   = m_ws_q.pop_front();
        for (int b = 0; b < 4; b++)
          if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        m_regwr = 8'(1 << idx);
        m_bv    = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("awready", {31'h0, bus.awready}, {31'h0, !reset && m_aw_q.size() == 0 && !m_bv});
    chk("wready",  {31'h0, bus.wready},  {31'h0, !reset && m_wd_q.size() == 0 && !m_bv});
    chk("bvalid",  {31'h0, bus.bvalid},  {31'h0, m_bv});
    chk("bresp",   {30'h0, bus.bresp},   32'h0);
    chk("reg_wr",  {24'h0, reg_wr},      {24'h0, m_regwr});
    for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), dut_r[i], m_regs[i]);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send_aw(input logic [4:0] a);
    bit ok = 1'b0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.awready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1 bus.awvalid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL aw_timeout: awaddr %h never accepted", a);
    end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.wready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1 bus.wvalid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL w_timeout: wdata %h never accepted", d);
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("lit_rst_awready", {31'h0, bus.awready}, 32'h1);
    chk("lit_rst_wready", {31'h0, bus.wready}, 32'h1);
    chk("lit_rst_r0", r0, 32'h0);
    sync();

    // Simultaneous AW/W
    fork
      send_aw(5'h08);
      send_w(32'hDEADBEEF, 4'hF);
    join
    @(negedge clk);
    chk("lit_sim_r2", r2, 32'hDEADBEEF);
    chk("lit_sim_regwr", {24'h0, reg_wr}, 32'h04);
    chk("lit_sim_bvalid", {31'h0, bus.bvalid}, 32'h1);
    @(negedge clk);
    chk("lit_sim_regwr_end", {24'h0, reg_wr}, 32'h0);
    chk("lit_sim_bvalid_end", {31'h0, bus.bvalid}, 32'h0);
    sync();

    // Address first, data three cycles later
    send_aw(5'h1C);
    repeat (3) begin
      @(negedge clk);
      chk("lit_af_awready", {31'h0, bus.awready}, 32'h0);
      chk("lit_af_r7_wait", r7, 32'h0);
    end
    sync();
    send_w(32'h12345678, 4'hF);
    @(negedge clk);
    chk("lit_af_r7", r7, 32'h12345678);
    chk("lit_af_regwr", {24'h0, reg_wr}, 32'h80);
    sync();

    // Data first, address later
    send_w(32'hA5A5A5A5, 4'hF);
    repeat (2) begin
      @(negedge clk);
      chk("lit_df_wready", {31'h0, bus.wready}, 32'h0);
    end
    sync();
    send_aw(5'h00);
    @(negedge clk);
    chk("lit_df_r0", r0, 32'hA5A5A5A5);
    chk("lit_df_regwr", {24'h0, reg_wr}, 32'h01);
    sync();

    // Byte strobes
    fork send_aw(5'h0C); send_w(32'h11223344, 4'hF); join
    fork send_aw(5'h0C); send_w(32'hAABBCCDD, 4'h5); join
    @(negedge clk);
    chk("lit_strb_r3", r3, 32'h11BB33DD);
    sync();
    fork send_aw(5'h0C); send_w(32'hFFFFFFFF, 4'h0); join
    @(negedge clk);
    chk("lit_strb0_r3", r3, 32'h11BB33DD);
    chk("lit_strb0_regwr", {24'h0, reg_wr}, 32'h08);
    chk("lit_strb0_bvalid", {31'h0, bus.bvalid}, 32'h1);
    sync();

    // Backpressure on B, unaligned address, pending AW during RESP
    bus.bready = 1'b0;
    fork send_aw(5'h0B); send_w(32'h01020304, 4'hF); join
    fork
      send_aw(5'h10);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("lit_bp_bvalid", {31'h0, bus.bvalid}, 32'h1);
          chk("lit_bp_awready", {31'h0, bus.awready}, 32'h0);
          chk("lit_bp_wready", {31'h0, bus.wready}, 32'h0);
        end
        bus.bready = 1'b1;
      end
    join
    chk("lit_bp_r2", r2, 32'h01020304);
    send_w(32'h05060708, 4'hF);
    @(negedge clk);
    chk("lit_bp_r4", r4, 32'h05060708);
    chk("lit_bp_regwr", {24'h0, reg_wr}, 32'h10);
    sync();

    // Reset while an address is held
    send_aw(5'h04);
    #3 reset = 1'b1;
    #1;
    chk("lit_ra_awready", {31'h0, bus.awready}, 32'h0);
    chk("lit_ra_wready", {31'h0, bus.wready}, 32'h0);
    chk("lit_ra_r2", r2, 32'h0);
    chk("lit_ra_r7", r7, 32'h0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_ra_rel_awready", {31'h0, bus.awready}, 32'h1);
    chk("lit_ra_rel_wready", {31'h0, bus.wready}, 32'h1);
    sync();
    send_w(32'hCAFEF00D, 4'hF);
    @(negedge clk);
    chk("lit_ra_no_commit", {24'h0, reg_wr}, 32'h0);
    chk("lit_ra_r1", r1, 32'h0);
    sync();
    send_aw(5'h14);
    @(negedge clk);
    chk("lit_ra_r5", r5, 32'hCAFEF00D);
    sync();

    // Reset while bvalid is pending
    bus.bready = 1'b0;
    fork send_aw(5'h18); send_w(32'h77777777, 4'hF); join
    @(negedge clk);
    chk("lit_rb_bvalid", {31'h0, bus.bvalid}, 32'h1);
    chk("lit_rb_r6", r6, 32'h77777777);
    #2 reset = 1'b1;
    #1;
    chk("lit_rb_bvalid_rst", {31'h0, bus.bvalid}, 32'h0);
    chk("lit_rb_r6_rst", r6, 32'h0);
    sync();
    reset = 1'b0;
    bus.bready = 1'b1;
    @(negedge clk);
    chk("lit_rb_rel_awready", {31'h0, bus.awready}, 32'h1);
    sync();
    fork send_aw(5'h00); send_w(32'h00000001, 4'h1); join
    @(negedge clk);
    chk("lit_final_r0", r0, 32'h00000001);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
